// File: rtl/d20_roll_sequencer_pkg.sv
// Shared types, constants and arithmetic helpers for the d20 roll sequencer.
package d20_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CALC  = 3'd3,
        RESP  = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ADV    = 2'd1,
        DIS    = 2'd2
    } roll_mode_t;

    localparam int DIE_MIN = 1;
    localparam int DIE_MAX = 20;

    localparam logic [1:0] CRIT_NONE  = 2'b00;
    localparam logic [1:0] CRIT_NAT20 = 2'b01;
    localparam logic [1:0] CRIT_NAT1  = 2'b10;

    // Clamp a + b into the signed range of a bits-wide result.
    function automatic int sat_add(input int a, input int b, input int bits);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (1 <<< (bits - 1)) - 1;
        lo  = -(1 <<< (bits - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

    // Encoding 11 is not a roll type and falls back to a normal roll.
    function automatic roll_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return ADV;
            2'b10:   return DIS;
            default: return NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/d20_roll_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                gnt[w_cand]  = 1'b1;
                gnt_idx      = w_cand;
            end
        end
    end

endmodule

// File: rtl/d20_roll_sequencer.sv
// Shares one d20 generator among NUM_REQ requesters: arbitrates, draws one or two
// dice (rerolling out-of-range values), applies modifier and target, reports result.
module d20_roll_sequencer
    import d20_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 8,
    parameter int DIE_BITS = 5,
    parameter int TIMEOUT  = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*NUM_BITS-1:0]  req_mod,
    input  logic [NUM_REQ*NUM_BITS-1:0]  req_target,
    input  logic [NUM_REQ*2-1:0]         req_mode,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         rng_next,
    input  logic                         rng_valid,
    input  logic [DIE_BITS-1:0]          rng_num,
    output logic                         resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [DIE_BITS-1:0]          resp_die,
    output logic [NUM_BITS-1:0]          resp_total,
    output logic                         resp_hit,
    output logic [1:0]                   resp_crit,
    output logic                         resp_err,
    output logic                         busy,
    output logic [2:0]                   dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    // Handshake: req is a level held until its resp_valid; rng_next is a one-cycle
    // pulse and the generator answers with a one-cycle rng_valid at any later time;
    // resp_valid is a one-cycle strobe with no back-pressure.

    seq_state_t                  r_state;
    logic [NUM_REQ-1:0]          r_grant;
    logic                        r_rng_next;
    logic                        r_resp_valid;
    logic [IDX_W-1:0]            r_resp_id;
    logic [DIE_BITS-1:0]         r_resp_die;
    logic [NUM_BITS-1:0]         r_resp_total;
    logic                        r_resp_hit;
    logic [1:0]                  r_resp_crit;
    logic                        r_resp_err;
    logic [IDX_W-1:0]            r_rr_ptr;
    logic [IDX_W-1:0]            r_win_id;
    logic signed [NUM_BITS-1:0]  r_mod;
    logic signed [NUM_BITS-1:0]  r_target;
    roll_mode_t                  r_mode;
    logic [DIE_BITS-1:0]         r_draw1;
    logic [DIE_BITS-1:0]         r_draw2;
    logic                        r_have1;
    logic                        r_err;
    logic [TMO_W-1:0]            r_tmo_cnt;

    logic [NUM_REQ-1:0]          w_gnt;
    logic [IDX_W-1:0]            w_gnt_idx;
    logic [IDX_W-1:0]            w_ptr_next;
    logic                        w_in_range;
    logic [DIE_BITS-1:0]         w_die;
    logic signed [31:0]          w_sum;
    logic                        w_hit;
    logic [1:0]                  w_crit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_ptr_next = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_in_range = (rng_num >= DIE_BITS'(DIE_MIN)) && (rng_num <= DIE_BITS'(DIE_MAX));

    always_comb begin
        w_die = r_draw1;
        case (r_mode)
            ADV:     if (r_draw2 > r_draw1) w_die = r_draw2;
            DIS:     if (r_draw2 < r_draw1) w_die = r_draw2;
            default: w_die = r_draw1;
        endcase
    end

    assign w_sum = sat_add(int'(w_die), int'(r_mod), NUM_BITS);

    always_comb begin
        w_hit  = (w_sum >= int'(r_target));
        w_crit = CRIT_NONE;
        if (w_die == DIE_BITS'(DIE_MAX)) begin
            w_hit  = 1'b1;
            w_crit = CRIT_NAT20;
        end else if (w_die == DIE_BITS'(DIE_MIN)) begin
            w_hit  = 1'b0;
            w_crit = CRIT_NAT1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rng_next   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_die   <= '0;
            r_resp_total <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_crit  <= CRIT_NONE;
            r_resp_err   <= 1'b0;
            r_rr_ptr     <= '0;
            r_win_id     <= '0;
            r_mod        <= '0;
            r_target     <= '0;
            r_mode       <= NORMAL;
            r_draw1      <= '0;
            r_draw2      <= '0;
            r_have1      <= 1'b0;
            r_err        <= 1'b0;
            r_tmo_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant    <= w_gnt;
                        r_win_id   <= w_gnt_idx;
                        r_rr_ptr   <= w_ptr_next;
                        r_mod      <= req_mod[int'(w_gnt_idx)*NUM_BITS +: NUM_BITS];
                        r_target   <= req_target[int'(w_gnt_idx)*NUM_BITS +: NUM_BITS];
                        r_mode     <= decode_mode(req_mode[int'(w_gnt_idx)*2 +: 2]);
                        r_have1    <= 1'b0;
                        r_err      <= 1'b0;
                        r_rng_next <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_rng_next <= 1'b0;
                    r_tmo_cnt  <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (rng_valid) begin
                        if (!w_in_range) begin
                            r_rng_next <= 1'b1;
                            r_state    <= ISSUE;
                        end else if (!r_have1) begin
                            r_draw1 <= rng_num;
                            r_have1 <= 1'b1;
                            if (r_mode != NORMAL) begin
                                r_rng_next <= 1'b1;
                                r_state    <= ISSUE;
                            end else begin
                                r_state <= CALC;
                            end
                        end else begin
                            r_draw2 <= rng_num;
                            r_state <= CALC;
                        end
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // Timeout shares the CALC stage, so it leaves with zeroed fields.
                        r_err   <= 1'b1;
                        r_state <= CALC;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                CALC: begin
                    r_resp_valid <= 1'b1;
                    r_resp_id    <= r_win_id;
                    if (r_err) begin
                        r_resp_err   <= 1'b1;
                        r_resp_die   <= '0;
                        r_resp_total <= '0;
                        r_resp_hit   <= 1'b0;
                        r_resp_crit  <= CRIT_NONE;
                    end else begin
                        r_resp_err   <= 1'b0;
                        r_resp_die   <= w_die;
                        r_resp_total <= w_sum[NUM_BITS-1:0];
                        r_resp_hit   <= w_hit;
                        r_resp_crit  <= w_crit;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_id    <= '0;
                    r_resp_die   <= '0;
                    r_resp_total <= '0;
                    r_resp_hit   <= 1'b0;
                    r_resp_crit  <= CRIT_NONE;
                    r_resp_err   <= 1'b0;
                    r_grant      <= '0;
                    r_have1      <= 1'b0;
                    r_err        <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant      = r_grant;
    assign rng_next   = r_rng_next;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_die   = r_resp_die;
    assign resp_total = r_resp_total;
    assign resp_hit   = r_resp_hit;
    assign resp_crit  = r_resp_crit;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_d20_roll_sequencer.sv
// Directed bench for d20_roll_sequencer: hand-computed rolls, arbitration order,
// rerolls, saturation, timeout and mid-roll reset.
module tb_d20_roll_sequencer;

    localparam int NR  = 4;
    localparam int NB  = 8;
    localparam int DB  = 5;
    localparam int TMO = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*NB-1:0]  req_mod = '0;
    logic [NR*NB-1:0]  req_target = '0;
    logic [NR*2-1:0]   req_mode = '0;
    logic [NR-1:0]     grant;
    logic              rng_next;
    logic              rng_valid = 1'b0;
    logic [DB-1:0]     rng_num = '0;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [DB-1:0]     resp_die;
    logic [NB-1:0]     resp_total;
    logic              resp_hit;
    logic [1:0]        resp_crit;
    logic              resp_err;
    logic              busy;
    logic [2:0]        dbg_state;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int n_next    = 0;

    logic [DB-1:0] draw_q[$];
    logic [1:0]    exp_q[$];

    d20_roll_sequencer #(
        .NUM_REQ  (NR),
        .NUM_BITS (NB),
        .DIE_BITS (DB),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_mod    (req_mod),
        .req_target (req_target),
        .req_mode   (req_mode),
        .grant      (grant),
        .rng_next   (rng_next),
        .rng_valid  (rng_valid),
        .rng_num    (rng_num),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_die   (resp_die),
        .resp_total (resp_total),
        .resp_hit   (resp_hit),
        .resp_crit  (resp_crit),
        .resp_err   (resp_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // generator model: answers each rng_next one cycle later with the next queued draw
    initial begin
        forever begin
            @(negedge clk);
            if (rng_next && reset) begin
                n_next++;
                if (draw_q.size() > 0) begin
                    @(posedge clk);
                    #1;
                    rng_valid = 1'b1;
                    rng_num   = draw_q.pop_front();
                    @(posedge clk);
                    #1;
                    rng_valid = 1'b0;
                    rng_num   = '0;
                end
            end
        end
    end

    task automatic set_slot(input int id, input int mod, input int tgt, input logic [1:0] mode);
        logic [31:0] m;
        logic [31:0] t;
        m = mod;
        t = tgt;
        req_mod[id*NB +: NB]    = m[NB-1:0];
        req_target[id*NB +: NB] = t[NB-1:0];
        req_mode[id*2 +: 2]     = mode;
    endtask

    // raises req[id] in an IDLE cycle (cycle 0), waits for resp_valid, drops req
    task automatic do_roll(input int id, input int exp_lat);
        int lat;
        @(negedge clk);
        req[id] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 200);
        req[id] = 1'b0;
        check("latency", lat, exp_lat);
    endtask

    task automatic chk_resp(input int id, input int die, input int total, input int hit,
                            input int crit, input int err);
        check("resp_valid", resp_valid, 1);
        check("resp_id", resp_id, id);
        check("resp_die", resp_die, die);
        check("resp_total", int'($signed(resp_total)), total);
        check("resp_hit", resp_hit, hit);
        check("resp_crit", resp_crit, crit);
        check("resp_err", resp_err, err);
    endtask

    initial begin
        int lat;
        int prev;
        int seen;
        int wcnt;
        logic [DB-1:0] rr_draws [5];
        rr_draws = '{5'd3, 5'd8, 5'd12, 5'd15, 5'd6};

        // reset
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_next", rng_next, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_total", resp_total, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;
        @(negedge clk);

        // normal roll: 7 + 5 = 12 >= 10
        set_slot(0, 5, 10, 2'b00);
        draw_q.push_back(5'd7);
        do_roll(0, 4);
        chk_resp(0, 7, 12, 1, 0, 0);
        check("t1_grant", grant, 4'b0001);
        @(negedge clk);
        check("t1_busy_after", busy, 0);
        check("t1_grant_after", grant, 0);
        check("t1_valid_after", resp_valid, 0);

        // advantage: max(4,17) - 3 = 14
        set_slot(1, -3, 0, 2'b01);
        draw_q.push_back(5'd4);
        draw_q.push_back(5'd17);
        do_roll(1, 6);
        chk_resp(1, 17, 14, 1, 0, 0);

        // disadvantage: min(4,17) - 3 = 1
        set_slot(1, -3, 0, 2'b10);
        draw_q.push_back(5'd4);
        draw_q.push_back(5'd17);
        do_roll(1, 6);
        chk_resp(1, 4, 1, 1, 0, 0);

        // natural 20 forces hit although 10 >= 5 anyway; crit 01
        set_slot(2, -10, 5, 2'b00);
        draw_q.push_back(5'd20);
        do_roll(2, 4);
        chk_resp(2, 20, 10, 1, 1, 0);

        // natural 1 forces miss although 11 >= 0; crit 10
        set_slot(3, 10, 0, 2'b00);
        draw_q.push_back(5'd1);
        do_roll(3, 4);
        chk_resp(3, 1, 11, 0, 2, 0);

        // rejects 0 and 25, then 20 + 127 saturates to 127
        set_slot(0, 127, 100, 2'b00);
        n_next = 0;
        draw_q.push_back(5'd0);
        draw_q.push_back(5'd25);
        draw_q.push_back(5'd20);
        do_roll(0, 8);
        chk_resp(0, 20, 127, 1, 1, 0);
        check("reroll_pulses", n_next, 3);

        // 10 + 120 saturates to 127, equal to target counts as hit
        set_slot(0, 120, 127, 2'b00);
        draw_q.push_back(5'd10);
        do_roll(0, 4);
        chk_resp(0, 10, 127, 1, 0, 0);

        // mode 11 rolls as normal: one draw, 9 < 10
        set_slot(1, 0, 10, 2'b11);
        draw_q.push_back(5'd9);
        do_roll(1, 4);
        chk_resp(1, 9, 9, 0, 0, 0);

        // negative signed compare: 3 - 30 = -27 < -25
        set_slot(2, -30, -25, 2'b00);
        draw_q.push_back(5'd3);
        do_roll(2, 4);
        chk_resp(2, 3, -27, 0, 0, 0);

        // reset during WAIT aborts with no response
        set_slot(2, 0, 0, 2'b00);
        @(negedge clk);
        req[2] = 1'b1;
        lat = 0;
        while (!rng_next && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("mid_saw_next", rng_next, 1);
        @(negedge clk);
        check("mid_in_wait", dbg_state, 2);
        reset = 1'b0;
        #1;
        check("mid_grant", grant, 0);
        check("mid_busy", busy, 0);
        check("mid_state", dbg_state, 0);
        check("mid_next", rng_next, 0);
        check("mid_valid", resp_valid, 0);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("mid_no_resp", seen, 0);

        // round robin from a fresh pointer with all requesters held
        for (int i = 0; i < NR; i++) set_slot(i, 0, 0, 2'b00);
        for (int i = 0; i < 5; i++) draw_q.push_back(rr_draws[i]);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        @(negedge clk);
        req  = '1;
        lat  = 0;
        prev = 0;
        for (int r = 0; r < 5; r++) begin
            logic [1:0] exp_id;
            wcnt = 0;
            do begin
                @(negedge clk);
                lat++;
                wcnt++;
                check("rr_onehot", ($countones(grant) <= 1), 1);
            end while (!resp_valid && wcnt < 200);
            exp_id = exp_q.pop_front();
            check("rr_id", resp_id, exp_id);
            check("rr_grant", grant, 32'(1) << exp_id);
            check("rr_die", resp_die, rr_draws[r]);
            if (r == 0) check("rr_first_lat", lat, 4);
            else        check("rr_gap", lat - prev, 5);
            prev = lat;
            if (r == 4) req = '0;
        end

        // silent generator: resp_err TIMEOUT+2 cycles after rng_next (cycle 1)
        set_slot(0, 3, 3, 2'b00);
        do_roll(0, 1 + TMO + 2);
        chk_resp(0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
